// File: rtl/multicycle_controller.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer
// with memory handshake stall, illegal/timeout halt and retire counter.
module multicycle_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [10:0]      Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IRWrite,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       ALUOp,
  output logic             Branch,
  output logic             Uncond,
  output logic [2:0]       State,
  output logic             Illegal,
  output logic             Timeout,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_R    = 3'd1;
  localparam logic [2:0] C_LD   = 3'd2;
  localparam logic [2:0] C_ST   = 3'd3;
  localparam logic [2:0] C_CBZ  = 3'd4;
  localparam logic [2:0] C_B    = 3'd5;
  localparam logic [2:0] C_ILL  = 3'd6;

  localparam int WAIT_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TO_EN = (MEM_TIMEOUT > 0);
  // Limit is hit when the counter is one short and MemReady is still low
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        cls_q, cls_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        dec_cls;
  logic              retire;

  always_comb begin
    dec_cls = C_ILL;
    if (Opcode[10:3] == 8'b10110100) begin
      dec_cls = C_CBZ;
    end else if (Opcode[10:5] == 6'b000101) begin
      dec_cls = C_B;
    end else begin
      case (Opcode)
        11'b10001011000,
        11'b11001011000,
        11'b10001010000,
        11'b10101010000: dec_cls = C_R;
        11'b11111000010: dec_cls = C_LD;
        11'b11111000000: dec_cls = C_ST;
        default:         dec_cls = C_ILL;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    wait_d    = wait_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == C_ILL) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_R:        state_d = S_WB;
          C_LD, C_ST: state_d = S_MEM;
          C_CBZ, C_B: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (MemReady) begin
          wait_d = '0;
          if (cls_q == C_LD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (TO_EN && wait_q == WAIT_LAST) begin
          wait_d    = '0;
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else if (wait_q != '1) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NONE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = 2'b00;
    Branch   = 1'b0;
    Uncond   = 1'b0;
    if (!Reset) begin
      case (state_q)
        S_FETCH: IRWrite = 1'b1;
        S_EXEC: begin
          case (cls_q)
            C_R: ALUOp = 2'b10;
            C_LD, C_ST: ALUSrc = 1'b1;
            C_CBZ: begin
              Reg2Loc = 1'b1;
              ALUOp   = 2'b01;
              Branch  = 1'b1;
              PCWrite = 1'b1;
              PCSrc   = Zero;
            end
            C_B: begin
              Uncond  = 1'b1;
              PCWrite = 1'b1;
              PCSrc   = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          ALUSrc = 1'b1;
          if (cls_q == C_LD) begin
            MemRead = 1'b1;
          end else begin
            MemWrite = 1'b1;
            Reg2Loc  = 1'b1;
            PCWrite  = MemReady;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = (cls_q == C_LD);
          PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign State      = state_q;
  assign Illegal    = illegal_q;
  assign Timeout    = timeout_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state/strobe
// vectors per instruction class, halts, reset and counter wrap.
module tb_multicycle_controller;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [10:0] Opcode;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrc, MemtoReg;
  logic        RegWrite, MemRead, MemWrite, Branch, Uncond;
  logic [1:0]  ALUOp;
  logic [2:0]  State;
  logic        Illegal, Timeout;
  logic [15:0] InstrCount;

  logic        w_pcw, w_pcs, w_irw, w_r2l, w_als, w_m2r;
  logic        w_rgw, w_mrd, w_mwr, w_br, w_un, w_ill, w_to;
  logic [1:0]  w_aop;
  logic [2:0]  w_st;
  logic [1:0]  w_cnt;

  always #5 Clock = ~Clock;

  multicycle_controller #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUOp(ALUOp), .Branch(Branch),
    .Uncond(Uncond), .State(State), .Illegal(Illegal),
    .Timeout(Timeout), .InstrCount(InstrCount)
  );

  multicycle_controller #(.CNT_W(2), .MEM_TIMEOUT(15)) dut_w (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(w_pcw), .PCSrc(w_pcs),
    .IRWrite(w_irw), .Reg2Loc(w_r2l), .ALUSrc(w_als),
    .MemtoReg(w_m2r), .RegWrite(w_rgw), .MemRead(w_mrd),
    .MemWrite(w_mwr), .ALUOp(w_aop), .Branch(w_br),
    .Uncond(w_un), .State(w_st), .Illegal(w_ill),
    .Timeout(w_to), .InstrCount(w_cnt)
  );

  // {PCWrite,PCSrc,IRWrite,Reg2Loc,ALUSrc,MemtoReg,RegWrite,
  //  MemRead,MemWrite,ALUOp,Branch,Uncond}
  logic [12:0] ctl;
  assign ctl = {PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrc, MemtoReg,
                RegWrite, MemRead, MemWrite, ALUOp, Branch, Uncond};

  localparam logic [12:0] C_IDLE  = 13'b0000000000000;
  localparam logic [12:0] C_FETCH = 13'b0010000000000;
  localparam logic [12:0] C_EXR   = 13'b0000000001000;
  localparam logic [12:0] C_WBR   = 13'b1000001000000;
  localparam logic [12:0] C_EXM   = 13'b0000100000000;
  localparam logic [12:0] C_MLD   = 13'b0000100100000;
  localparam logic [12:0] C_WBL   = 13'b1000011000000;
  localparam logic [12:0] C_MST   = 13'b0001100010000;
  localparam logic [12:0] C_MSTR  = 13'b1001100010000;
  localparam logic [12:0] C_CBZ1  = 13'b1101000000110;
  localparam logic [12:0] C_CBZ0  = 13'b1001000000110;
  localparam logic [12:0] C_B     = 13'b1100000000001;

  localparam logic [2:0] S0 = 3'd0, S1 = 3'd1, S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3, S4 = 3'd4, S5 = 3'd5;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010111001;

  // {MemReady, Zero, State, ctl}
  typedef logic [17:0] vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    MemReady = 1'b0;
    Zero     = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset    = 1'b1;
    Opcode   = OP_ADD;
    MemReady = 1'b0;
    Zero     = 1'b1;
    step();
    step();
    n_checks++;
    if ({State, ctl} !== {S0, C_IDLE}) begin
      n_fail++;
      $display("FAIL reset_state: got %0d/%b want 0/%b",
               State, ctl, C_IDLE);
    end
    n_checks++;
    if ({Illegal, Timeout, InstrCount} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got ill=%b to=%b cnt=%0d want 0",
               Illegal, Timeout, InstrCount);
    end
    Reset = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_FETCH) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", ctl, C_FETCH);
    end
  endtask

  task automatic test_add();
    vec_t v[$];
    do_reset();
    Opcode = OP_ADD;
    v = '{{2'b00, S0, C_FETCH}, {2'b00, S1, C_IDLE},
          {2'b00, S2, C_EXR},   {2'b00, S4, C_WBR},
          {2'b00, S0, C_FETCH}};
    foreach (v[i]) begin
      MemReady = v[i][17];
      Zero     = v[i][16];
      #1;
      n_checks++;
      if ({State, ctl} !== v[i][15:0]) begin
        n_fail++;
        $display("FAIL add c%0d: got %0d/%b want %0d/%b",
                 i, State, ctl, v[i][15:13], v[i][12:0]);
      end
      if (i < v.size() - 1) step();
    end
    n_checks++;
    if (InstrCount !== 16'd1) begin
      n_fail++;
      $display("FAIL add_count: got %0d want 1", InstrCount);
    end
    step();
  endtask

  task automatic test_ldur();
    vec_t v[$];
    do_reset();
    Opcode = OP_LDUR;
    v = '{{2'b00, S0, C_FETCH}, {2'b00, S1, C_IDLE},
          {2'b00, S2, C_EXM},   {2'b00, S3, C_MLD},
          {2'b00, S3, C_MLD},   {2'b10, S3, C_MLD},
          {2'b00, S4, C_WBL},   {2'b00, S0, C_FETCH}};
    foreach (v[i]) begin
      MemReady = v[i][17];
      Zero     = v[i][16];
      #1;
      n_checks++;
      if ({State, ctl} !== v[i][15:0]) begin
        n_fail++;
        $display("FAIL ldur c%0d: got %0d/%b want %0d/%b",
                 i, State, ctl, v[i][15:13], v[i][12:0]);
      end
      if (i < v.size() - 1) step();
    end
    n_checks++;
    if (InstrCount !== 16'd1) begin
      n_fail++;
      $display("FAIL ldur_count: got %0d want 1", InstrCount);
    end
    step();
  endtask

  task automatic test_cbz();
    vec_t v[$];
    do_reset();
    Opcode = OP_CBZ;
    v = '{{2'b00, S0, C_FETCH}, {2'b00, S1, C_IDLE},
          {2'b01, S2, C_CBZ1},  {2'b00, S0, C_FETCH},
          {2'b00, S1, C_IDLE},  {2'b00, S2, C_CBZ0},
          {2'b00, S0, C_FETCH}};
    foreach (v[i]) begin
      MemReady = v[i][17];
      Zero     = v[i][16];
      #1;
      n_checks++;
      if ({State, ctl} !== v[i][15:0]) begin
        n_fail++;
        $display("FAIL cbz c%0d: got %0d/%b want %0d/%b",
                 i, State, ctl, v[i][15:13], v[i][12:0]);
      end
      if (i < v.size() - 1) step();
    end
    n_checks++;
    if (InstrCount !== 16'd2) begin
      n_fail++;
      $display("FAIL cbz_count: got %0d want 2", InstrCount);
    end
    step();
  endtask

  task automatic test_illegal();
    vec_t v[$];
    do_reset();
    Opcode = 11'b00000000000;
    v.push_back({2'b00, S0, C_FETCH});
    v.push_back({2'b00, S1, C_IDLE});
    for (int k = 0; k < 10; k++) v.push_back({2'b00, S5, C_IDLE});
    foreach (v[i]) begin
      MemReady = v[i][17];
      Zero     = v[i][16];
      #1;
      n_checks++;
      if ({State, ctl} !== v[i][15:0]) begin
        n_fail++;
        $display("FAIL illegal c%0d: got %0d/%b want %0d/%b",
                 i, State, ctl, v[i][15:13], v[i][12:0]);
      end
      step();
    end
    n_checks++;
    if ({Illegal, Timeout, InstrCount} !== {2'b10, 16'd0}) begin
      n_fail++;
      $display("FAIL illegal_flags: got ill=%b to=%b cnt=%0d want 1,0,0",
               Illegal, Timeout, InstrCount);
    end
    do_reset();
    #1;
    n_checks++;
    if ({State, Illegal} !== {S0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_clear: got st=%0d ill=%b want 0,0",
               State, Illegal);
    end
  endtask

  task automatic test_timeout();
    vec_t v[$];
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      Opcode = OP_STUR;
      v.delete();
      v.push_back({2'b00, S0, C_FETCH});
      v.push_back({2'b00, S1, C_IDLE});
      v.push_back({2'b00, S2, C_EXM});
      for (int k = 0; k < 14; k++) v.push_back({2'b00, S3, C_MST});
      if (pass == 0) begin
        v.push_back({2'b00, S3, C_MST});
        v.push_back({2'b00, S5, C_IDLE});
      end else begin
        v.push_back({2'b10, S3, C_MSTR});
        v.push_back({2'b00, S0, C_FETCH});
      end
      foreach (v[i]) begin
        MemReady = v[i][17];
        Zero     = v[i][16];
        #1;
        n_checks++;
        if ({State, ctl} !== v[i][15:0]) begin
          n_fail++;
          $display("FAIL timeout%0d c%0d: got %0d/%b want %0d/%b",
                   pass, i, State, ctl, v[i][15:13], v[i][12:0]);
        end
        if (i < v.size() - 1) step();
      end
      n_checks++;
      if (pass == 0 && {Timeout, Illegal, InstrCount} !==
          {2'b10, 16'd0}) begin
        n_fail++;
        $display("FAIL timeout_hit: got to=%b ill=%b cnt=%0d want 1,0,0",
                 Timeout, Illegal, InstrCount);
      end else if (pass == 1 && {Timeout, InstrCount} !==
                   {1'b0, 16'd1}) begin
        n_fail++;
        $display("FAIL timeout_ready: got to=%b cnt=%0d want 0,1",
                 Timeout, InstrCount);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_mem();
    vec_t v[$];
    do_reset();
    Opcode = OP_ADD;
    for (int k = 0; k < 4; k++) step();
    Opcode = OP_LDUR;
    v = '{{2'b00, S0, C_FETCH}, {2'b00, S1, C_IDLE},
          {2'b00, S2, C_EXM},   {2'b00, S3, C_MLD}};
    foreach (v[i]) begin
      MemReady = v[i][17];
      Zero     = v[i][16];
      #1;
      n_checks++;
      if ({State, ctl} !== v[i][15:0]) begin
        n_fail++;
        $display("FAIL midmem c%0d: got %0d/%b want %0d/%b",
                 i, State, ctl, v[i][15:13], v[i][12:0]);
      end
      step();
    end
    n_checks++;
    if (InstrCount !== 16'd1) begin
      n_fail++;
      $display("FAIL midmem_pre: got cnt=%0d want 1", InstrCount);
    end
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({State, ctl} !== {S3, C_IDLE}) begin
      n_fail++;
      $display("FAIL midmem_force: got %0d/%b want 3/%b",
               State, ctl, C_IDLE);
    end
    step();
    n_checks++;
    if ({State, ctl, InstrCount} !== {S0, C_IDLE, 16'd0}) begin
      n_fail++;
      $display("FAIL midmem_reset: got %0d/%b cnt=%0d want 0/%b cnt=0",
               State, ctl, InstrCount, C_IDLE);
    end
    Reset = 1'b0;
  endtask

  task automatic test_wrap();
    vec_t v[$];
    do_reset();
    Opcode = OP_B;
    for (int k = 0; k < 5; k++) begin
      v.push_back({2'b00, S0, C_FETCH});
      v.push_back({2'b00, S1, C_IDLE});
      v.push_back({2'b00, S2, C_B});
    end
    foreach (v[i]) begin
      MemReady = v[i][17];
      Zero     = v[i][16];
      #1;
      n_checks++;
      if ({State, ctl} !== v[i][15:0]) begin
        n_fail++;
        $display("FAIL wrap c%0d: got %0d/%b want %0d/%b",
                 i, State, ctl, v[i][15:13], v[i][12:0]);
      end
      step();
    end
    n_checks++;
    if ({InstrCount, w_cnt} !== {16'd5, 2'd1}) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d/%0d want 5/1",
               InstrCount, w_cnt);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Opcode   = '0;
    Zero     = 1'b0;
    MemReady = 1'b0;
    test_reset();
    test_add();
    test_ldur();
    test_cbz();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle LEGv8 control unit that sequences the PC / instruction-memory / decode / register-file / ALU / data-memory datapath.
- Replaces single-cycle decode: each instruction is walked through FETCH, DECODE, EXEC, MEM and WB states.
- Asserts per-state control strobes, PC/IR write enables and branch selection.
- Stalls on data-memory handshake, halts on illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- CNT_W, 16: width of retired-instruction counter.
- MEM_TIMEOUT, 15: max MEM wait cycles before halt; 0 disables timeout.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Opcode  input  11  IR[31:21]; stable from DECODE until the next FETCH.
- Zero  input  1  ALU zero flag, sampled in EXEC.
- MemReady  input  1  data memory completion strobe.
- PCWrite  output  1  PC register load enable.
- PCSrc  output  1  0 = PC+4, 1 = branch target.
- IRWrite  output  1  instruction register load enable.
- Reg2Loc  output  1  register-file read-port-2 select.
- ALUSrc  output  1  0 = register, 1 = sign-extended immediate.
- MemtoReg  output  1  writeback source select.
- RegWrite  output  1  register-file write enable.
- MemRead  output  1  data memory read strobe.
- MemWrite  output  1  data memory write strobe.
- ALUOp  output  2  00 = add, 01 = pass B / zero test, 10 = R-type funct.
- Branch  output  1  conditional branch active.
- Uncond  output  1  unconditional branch active.
- State  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Illegal  output  1  sticky: unknown opcode decoded.
- Timeout  output  1  sticky: MEM wait exceeded MEM_TIMEOUT.
- InstrCount  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (any state, including mid-MEM):
  - State=FETCH, Illegal=0, Timeout=0, InstrCount=0, wait counter=0, class register=NONE.
  - While Reset=1, all control outputs are forced to 0.
- Class decode, performed in DECODE and registered into the class register:
  - R: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR.
  - LD: 11111000010 LDUR.
  - ST: 11111000000 STUR.
  - CBZ: Opcode[10:3]=10110100.
  - B: Opcode[10:5]=000101.
  - Anything else is ILL.
- Outputs are combinational from registered State and class. Any output not listed for a state is 0.
- FETCH: IRWrite=1. Next state DECODE.
- DECODE: no strobes.
  - ILL -> HALT, Illegal<=1.
  - Otherwise -> EXEC.
- EXEC:
  - R: ALUOp=10, ALUSrc=0. Next WB.
  - LD/ST: ALUOp=00, ALUSrc=1. Next MEM.
  - CBZ: Reg2Loc=1, ALUOp=01, Branch=1, PCWrite=1, PCSrc=Zero. Retire, next FETCH.
  - B: Uncond=1, PCWrite=1, PCSrc=1. Retire, next FETCH.
- MEM:
  - ALUSrc=1, ALUOp=00 held throughout.
  - LD: MemRead=1. ST: MemWrite=1, Reg2Loc=1.
  - Strobes are held every cycle until MemReady=1.
  - On MemReady: LD -> WB; ST -> PCWrite=1, PCSrc=0, retire, next FETCH.
  - Wait counter increments on each MEM cycle with MemReady=0 and clears on MEM exit.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with MemReady=0: -> HALT, Timeout<=1.
  - If MemReady=1 in the same cycle the limit is reached, MemReady wins (no timeout).
- WB:
  - RegWrite=1, MemtoReg=1 for LD and 0 for R, PCWrite=1, PCSrc=0.
  - Retire, next FETCH.
- HALT: all strobes 0; held until Reset.
- Retire means InstrCount increments by 1, wrapping modulo 2^CNT_W (all-ones -> 0). PCWrite pulses exactly once per retired instruction.
- Latency in cycles: R=4, LD=5+waits, ST=4+waits, CBZ=3, B=3.
- Unused state encodings 6 and 7 go to HALT with Illegal<=1.

Test Plan:
- Reset, then ADD (10001011000) -> State 0,1,2,4,0; ALUOp=10 in EXEC; RegWrite=1, PCWrite=1 only in WB; InstrCount=1.
- LDUR with MemReady rising on the 3rd MEM cycle -> MemRead=1 for exactly 3 cycles; WB has MemtoReg=1, RegWrite=1; 7 cycles total; InstrCount=1.
- CBZ with Zero=1, then CBZ with Zero=0 -> EXEC shows PCSrc=1 then 0, PCWrite=1, Branch=1, Reg2Loc=1; 3 cycles each; InstrCount=2.
- Opcode 00000000000 -> HALT after DECODE, Illegal=1, no PCWrite; stays in HALT 10 cycles; Reset returns State=0, Illegal=0.
- STUR with MemReady held 0, MEM_TIMEOUT=15 -> MemWrite=1 for 15 cycles, then HALT, Timeout=1; repeat with MemReady=1 on cycle 15 -> FETCH, no Timeout.
- Reset asserted in the 2nd MEM cycle of LDUR -> next cycle State=0, all strobes 0, InstrCount=0; CNT_W=2 run of 5 B instructions -> InstrCount wraps to 1.
